// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: oversampled SPI-slave debug bridge for the discus soft-CPU.
// A host shifts in 3-bit-opcode + DW-bit-data frames (MSB first, SPI mode 0).
// Each frame either sets the shared address, writes program/data memory, or
// reads it back. Readback data is returned on the data bits of the next frame.
//
// Optional feature macro: SPI_STATUS_EN
//   defined   -> opcode 110 loads readback with the framing-error count and
//                clears the count.
//   undefined -> opcode 110 is a nop; the error counter is still kept but
//                cannot be read.
module spi_mem_bridge #(
    parameter int AW   = 8,   // address width, 1 <= AW <= 2*DW
    parameter int DW   = 8,   // data width, >= 1
    parameter int SYNC = 2    // synchroniser depth, >= 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          spi_sck,
    input  logic          spi_ssel,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdata,
    output logic          prog_we,
    output logic          prog_re,
    input  logic [DW-1:0] prog_rdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
);

    localparam int FW      = 3 + DW;          // valid frame length in bits
    localparam int CNT_MAX = FW + 1;          // bit counter saturation value
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] FW_C      = CW'(FW);
    localparam logic [CW-1:0] CNT_MAX_C = CW'(CNT_MAX);
    localparam logic [CW-1:0] OP_BITS_C = CW'(3);

    localparam logic [2:0] OP_ADDR_LO = 3'b000;
    localparam logic [2:0] OP_ADDR_HI = 3'b001;
    localparam logic [2:0] OP_PROG_WR = 3'b010;
    localparam logic [2:0] OP_MEM_WR  = 3'b011;
    localparam logic [2:0] OP_MEM_RD  = 3'b100;
    localparam logic [2:0] OP_PROG_RD = 3'b101;
    localparam logic [2:0] OP_STATUS  = 3'b110;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        SHIFT     = 3'd2,
        EXEC      = 3'd3,
        RDCAP     = 3'd4
    } state_t;

    // ---------------------------------------------------------------
    // Input synchronisers and edge detection
    // ---------------------------------------------------------------
    logic [SYNC-1:0] sck_sync_q;
    logic [SYNC-1:0] ssel_sync_q;
    logic [SYNC-1:0] mosi_sync_q;
    logic            sck_prev_q;
    logic            ssel_prev_q;

    logic sck_s;
    logic ssel_s;
    logic mosi_s;
    logic sck_rise;
    logic ssel_rise;

    // Synchroniser chains plus one edge-detect flop for sck and ssel.
    // The ssel chain resets to 0 ("selected") so that a frame in flight at
    // reset keeps the FSM in WAIT_IDLE until the host really deselects.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sck_sync_q  <= '0;
            ssel_sync_q <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            ssel_prev_q <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC-2:0], spi_sck};
            ssel_sync_q <= {ssel_sync_q[SYNC-2:0], spi_ssel};
            mosi_sync_q <= {mosi_sync_q[SYNC-2:0], spi_mosi};
            sck_prev_q  <= sck_sync_q[SYNC-1];
            ssel_prev_q <= ssel_sync_q[SYNC-1];
        end
    end

    assign sck_s     = sck_sync_q[SYNC-1];
    assign ssel_s    = ssel_sync_q[SYNC-1];
    assign mosi_s    = mosi_sync_q[SYNC-1];
    // sck edges only count while selected
    assign sck_rise  = sck_s & ~sck_prev_q & ~ssel_s;
    assign ssel_rise = ssel_s & ~ssel_prev_q;

    // ---------------------------------------------------------------
    // Frame state
    // ---------------------------------------------------------------
    state_t          state_q, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FW-1:0]   shift_in_q, shift_in_d;
    logic [DW-1:0]   shift_out_q, shift_out_d;
    logic            miso_q, miso_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   readback_q, readback_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic [2:0]      opcode;
    logic [DW-1:0]   data;
    logic [AW-1:0]   addr_set_lo;
    logic [AW-1:0]   addr_set_hi;

    assign opcode = shift_in_q[FW-1:DW];
    assign data   = shift_in_q[DW-1:0];

    // Address-load values: a wide address is written in two halves,
    // a narrow one in a single frame (high-half opcode then does nothing).
    generate
        if (AW > DW) begin : g_wide_addr
            assign addr_set_lo = {addr_q[AW-1:DW], data};
            assign addr_set_hi = {data[AW-DW-1:0], addr_q[DW-1:0]};
        end else begin : g_narrow_addr
            assign addr_set_lo = data[AW-1:0];
            assign addr_set_hi = addr_q;
        end
    endgenerate

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= WAIT_IDLE;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            miso_q      <= 1'b0;
            addr_q      <= '0;
            readback_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            miso_q      <= miso_d;
            addr_q      <= addr_d;
            readback_q  <= readback_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    logic [CW-1:0] cnt_new;

    // Next-state, datapath update and single-cycle strobes.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        miso_d      = miso_q;
        addr_d      = addr_q;
        readback_d  = readback_q;
        err_cnt_d   = err_cnt_q;
        cnt_new     = '0;
        prog_we     = 1'b0;
        prog_re     = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;

        case (state_q)
            WAIT_IDLE: begin
                miso_d = 1'b0;
                if (ssel_s) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                miso_d = 1'b0;
                if (!ssel_s) begin
                    state_d     = SHIFT;
                    bit_cnt_d   = '0;
                    shift_out_d = readback_q;
                end
            end

            SHIFT: begin
                if (ssel_rise) begin
                    miso_d = 1'b0;
                    if (bit_cnt_q == FW_C) begin
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                end else if (sck_rise) begin
                    shift_in_d = {shift_in_q[FW-2:0], mosi_s};
                    cnt_new    = (bit_cnt_q == CNT_MAX_C) ? bit_cnt_q : bit_cnt_q + 1'b1;
                    bit_cnt_d  = cnt_new;
                    // After the opcode bits the readback word is presented
                    // MSB first, one bit ahead of the host's sampling edge.
                    if (cnt_new > OP_BITS_C) begin
                        shift_out_d = shift_out_q << 1;
                    end
                    if (cnt_new >= OP_BITS_C && cnt_new < FW_C) begin
                        miso_d = shift_out_d[DW-1];
                    end else begin
                        miso_d = 1'b0;
                    end
                end
            end

            EXEC: begin
                state_d = IDLE;
                case (opcode)
                    OP_ADDR_LO: addr_d = addr_set_lo;
                    OP_ADDR_HI: addr_d = addr_set_hi;
                    OP_PROG_WR: begin
                        prog_we = 1'b1;
                        addr_d  = addr_q + 1'b1;
                    end
                    OP_MEM_WR: begin
                        mem_we = 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                    OP_MEM_RD: begin
                        mem_re  = 1'b1;
                        addr_d  = addr_q + 1'b1;
                        state_d = RDCAP;
                    end
                    OP_PROG_RD: begin
                        prog_re = 1'b1;
                        addr_d  = addr_q + 1'b1;
                        state_d = RDCAP;
                    end
`ifdef SPI_STATUS_EN
                    OP_STATUS: begin
                        readback_d = DW'(err_cnt_q);
                        err_cnt_d  = '0;
                    end
`else
                    OP_STATUS: begin
                        readback_d = readback_q;
                    end
`endif
                    default: begin
                        addr_d = addr_q;
                    end
                endcase
            end

            RDCAP: begin
                state_d    = IDLE;
                readback_d = (opcode == OP_MEM_RD) ? mem_rdata : prog_rdata;
            end

            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
    end

    assign spi_miso = miso_q;
    assign addr     = addr_q;
    assign wdata    = data;

endmodule
